max_tree_sched: RTL and testbench

//  Iterative max-reduction scheduler. Time-shares one pairwise-max layer (CHANNELS lanes -> (CHANNELS+1)/2)

---
 rtl/max_tree_sched.sv | 140 ++++++++++++++
 tb/tb_max_tree_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/max_tree_sched.sv
// Iterative max-reduction scheduler: folds a CHANNELS-wide value vector through one shared
// pairwise-max layer, pass by pass, until a single maximum remains.
module max_tree_sched #(
   parameter int DATA_WIDTH   = 32,
   parameter int CHANNELS     = 4,
   parameter int WAIT_TIMEOUT = 16
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   valid_in,
   input  logic [DATA_WIDTH*CHANNELS-1:0]         in_data,
   output logic                                   ready,
   output logic                                   busy,
   output logic [DATA_WIDTH*CHANNELS-1:0]         layer_in,
   output logic                                   layer_valid_in,
   input  logic [((CHANNELS+1)/2)*DATA_WIDTH-1:0] layer_out,
   input  logic                                   layer_valid_out,
   output logic [DATA_WIDTH-1:0]                  max_out,
   output logic                                   valid_out,
   output logic                                   err
);

   localparam int HALF = (CHANNELS + 1) / 2;
   localparam int CW   = $clog2(CHANNELS + 1);
   localparam int WW   = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] lane_buf_q [CHANNELS];
   logic [DATA_WIDTH-1:0] lane_buf_d [CHANNELS];
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [WW-1:0]         wcnt_q, wcnt_d;
   logic [DATA_WIDTH-1:0] max_out_q, max_out_d;
   logic                  valid_out_q, valid_out_d;
   logic                  err_q, err_d;
   logic                  layer_valid_in_q, layer_valid_in_d;
   logic [CW:0]           cnt_inc;
   logic [CW-1:0]         half_cnt;
   logic [DATA_WIDTH-1:0] last_lane;

   // Extra bit so ceil(cnt/2) cannot wrap when cnt is the all-ones value.
   assign cnt_inc  = {1'b0, cnt_q} + (CW+1)'(1);
   assign half_cnt = cnt_inc[CW:1];

   // Lanes beyond the active count replicate the last active lane: max(x,x)=x, so no pad value.
   always_comb begin
      last_lane = lane_buf_q[0];
      for (int unsigned j = 0; j < CHANNELS; j++) begin
         if (CW'(j + 1) == cnt_q) last_lane = lane_buf_q[j];
      end
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         layer_in[i*DATA_WIDTH +: DATA_WIDTH] = (CW'(i) < cnt_q) ? lane_buf_q[i] : last_lane;
      end
   end

   always_comb begin
      state_d     = state_q;
      lane_buf_d  = lane_buf_q;
      cnt_d       = cnt_q;
      wcnt_d      = wcnt_q;
      max_out_d   = max_out_q;
      valid_out_d = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               for (int unsigned i = 0; i < CHANNELS; i++) begin
                  lane_buf_d[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
               end
               cnt_d = CW'(CHANNELS);
               if (CHANNELS == 1) begin
                  max_out_d   = in_data[DATA_WIDTH-1:0];
                  valid_out_d = 1'b1;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            wcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (layer_valid_out) begin
               for (int unsigned i = 0; i < HALF; i++) begin
                  if (CW'(i) < half_cnt) lane_buf_d[i] = layer_out[i*DATA_WIDTH +: DATA_WIDTH];
               end
               cnt_d = half_cnt;
               if (half_cnt == CW'(1)) begin
                  max_out_d   = layer_out[DATA_WIDTH-1:0];
                  valid_out_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  state_d = S_ISSUE;
               end
            end else if (wcnt_q == WW'(WAIT_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      layer_valid_in_d = (state_d == S_ISSUE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         for (int unsigned i = 0; i < CHANNELS; i++) lane_buf_q[i] <= '0;
         cnt_q            <= '0;
         wcnt_q           <= '0;
         max_out_q        <= '0;
         valid_out_q      <= 1'b0;
         err_q            <= 1'b0;
         layer_valid_in_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         lane_buf_q       <= lane_buf_d;
         cnt_q            <= cnt_d;
         wcnt_q           <= wcnt_d;
         max_out_q        <= max_out_d;
         valid_out_q      <= valid_out_d;
         err_q            <= err_d;
         layer_valid_in_q <= layer_valid_in_d;
      end
   end

   assign ready          = (state_q == S_IDLE);
   assign busy           = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign layer_valid_in = layer_valid_in_q;
   assign max_out        = max_out_q;
   assign valid_out      = valid_out_q;
   assign err            = err_q;

endmodule

// File: tb/tb_max_tree_sched.sv
// Bench for max_tree_sched: 4- and 5-lane instances, each with a latency-1 FP32 pairwise-max layer stub.
module tb_max_tree_sched;

   logic         clk = 1'b0;
   logic         rst = 1'b1;

   logic         vin4 = 1'b0, vin5 = 1'b0;
   logic [127:0] din4 = '0;
   logic [159:0] din5 = '0;
   logic         rdy4, busy4, lvi4, vout4, err4;
   logic         rdy5, busy5, lvi5, vout5, err5;
   logic [127:0] lin4;
   logic [159:0] lin5;
   logic [31:0]  mo4, mo5;
   logic [63:0]  layer_out4;
   logic [95:0]  layer_out5;
   logic         layer_valid_out4, layer_valid_out5;

   logic         mute4 = 1'b0, inj4 = 1'b0;
   logic [63:0]  inj_data4 = '0;
   logic [63:0]  lo4_q = '0;
   logic [95:0]  lo5_q = '0;
   logic         lvo4_q = 1'b0, lvo5_q = 1'b0;

   int           checks = 0;
   int           errors = 0;
   int           strb4 = 0, strb5 = 0;
   logic [159:0] hist5 [8];

   always #5 clk = ~clk;

   max_tree_sched #(.DATA_WIDTH(32), .CHANNELS(4), .WAIT_TIMEOUT(16)) u_dut4 (
      .clk(clk), .rst(rst), .valid_in(vin4), .in_data(din4), .ready(rdy4), .busy(busy4),
      .layer_in(lin4), .layer_valid_in(lvi4), .layer_out(layer_out4),
      .layer_valid_out(layer_valid_out4), .max_out(mo4), .valid_out(vout4), .err(err4)
   );

   max_tree_sched #(.DATA_WIDTH(32), .CHANNELS(5), .WAIT_TIMEOUT(16)) u_dut5 (
      .clk(clk), .rst(rst), .valid_in(vin5), .in_data(din5), .ready(rdy5), .busy(busy5),
      .layer_in(lin5), .layer_valid_in(lvi5), .layer_out(layer_out5),
      .layer_valid_out(layer_valid_out5), .max_out(mo5), .valid_out(vout5), .err(err5)
   );

   // IEEE-754 ordering via a monotonic unsigned key (sign-magnitude -> offset order).
   function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ka, kb;
      ka = a[31] ? ~a : (a | 32'h8000_0000);
      kb = b[31] ? ~b : (b | 32'h8000_0000);
      return (kb > ka) ? b : a;
   endfunction

   assign layer_out4       = inj4 ? inj_data4 : lo4_q;
   assign layer_valid_out4 = lvo4_q | inj4;
   assign layer_out5       = lo5_q;
   assign layer_valid_out5 = lvo5_q;

   always @(posedge clk) begin
      lvo4_q <= lvi4 & ~mute4;
      for (int k = 0; k < 2; k++)
         lo4_q[k*32 +: 32] <= fmax(lin4[2*k*32 +: 32], lin4[(2*k+1)*32 +: 32]);
      lvo5_q <= lvi5;
      for (int k = 0; k < 3; k++)
         lo5_q[k*32 +: 32] <= fmax(lin5[2*k*32 +: 32], lin5[((2*k+1 < 5) ? 2*k+1 : 2*k)*32 +: 32]);
   end

   always @(negedge clk) begin
      if (lvi4) strb4++;
      if (lvi5) begin
         hist5[strb5 % 8] = lin5;
         strb5++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int ch, input logic [159:0] d, input int budget,
                          output int lat, output int nstrb, output logic [31:0] mo, output int s0);
      lat = -1;
      s0  = (ch == 4) ? strb4 : strb5;
      if (ch == 4) begin din4 = d[127:0]; vin4 = 1'b1; end
      else         begin din5 = d;        vin5 = 1'b1; end
      for (int k = 1; k <= budget && lat < 0; k++) begin
         @(posedge clk); #1;
         vin4 = 1'b0;
         vin5 = 1'b0;
         if ((ch == 4) ? vout4 : vout5) lat = k;
      end
      nstrb = ((ch == 4) ? strb4 : strb5) - s0;
      mo    = (ch == 4) ? mo4 : mo5;
   endtask

   function automatic logic [159:0] pk(input logic [31:0] a0, input logic [31:0] a1,
                                       input logic [31:0] a2, input logic [31:0] a3,
                                       input logic [31:0] a4);
      return {a4, a3, a2, a1, a0};
   endfunction

   typedef struct {
      int           ch;
      logic [159:0] din;
      logic [31:0]  exp;
      int           lat;
      int           strb;
   } vec_t;

   vec_t tbl [7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, ns, s0, n_extra, lat_err, saw;
      logic [31:0] mo;
      logic [159:0] p1, p2;

      tbl[0] = '{4, pk(32'h3F800000, 32'h40600000, 32'hBF800000, 32'h40000000, 32'h0), 32'h40600000, 5, 2};
      tbl[1] = '{4, pk(32'hBF800000, 32'hBF000000, 32'hC0000000, 32'hC0600000, 32'h0), 32'hBF000000, 5, 2};
      tbl[2] = '{4, pk(32'h41200000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h0), 32'h41200000, 5, 2};
      tbl[3] = '{4, pk(32'hC1200000, 32'h42C80000, 32'h42C80000, 32'hC2C80000, 32'h0), 32'h42C80000, 5, 2};
      tbl[4] = '{5, pk(32'hBF800000, 32'h3F800000, 32'hBF000000, 32'h40000000, 32'h40600000), 32'h40600000, 7, 3};
      tbl[5] = '{5, pk(32'h42C80000, 32'h3F800000, 32'hBF000000, 32'h40000000, 32'h40600000), 32'h42C80000, 7, 3};
      tbl[6] = '{5, pk(32'hC0000000, 32'hC0400000, 32'hBF800000, 32'hC0800000, 32'hC1000000), 32'hBF800000, 7, 3};

      @(posedge clk); @(posedge clk); #1;
      chk("rst_ready4", {31'd0, rdy4}, 32'd1);
      chk("rst_busy4", {31'd0, busy4}, 32'd0);
      chk("rst_max4", mo4, 32'd0);
      chk("rst_vout4", {31'd0, vout4}, 32'd0);
      chk("rst_err4", {31'd0, err4}, 32'd0);
      chk("rst_lvi4", {31'd0, lvi4}, 32'd0);
      chk("rst_ready5", {31'd0, rdy5}, 32'd1);
      chk("rst_busy5", {31'd0, busy5 | err5}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         run_vec(tbl[i].ch, tbl[i].din, 30, lat, ns, mo, s0);
         chk($sformatf("vec%0d_max", i), mo, tbl[i].exp);
         chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
         chk($sformatf("vec%0d_strobes", i), ns, tbl[i].strb);
         @(posedge clk); #1;
      end

      // T2 lane-replication detail: pass 1 sees 5 live lanes, pass 2 has cnt=3 so lanes 3,4 copy lane 2.
      run_vec(5, tbl[4].din, 30, lat, ns, mo, s0);
      p1 = hist5[s0 % 8];
      p2 = hist5[(s0 + 1) % 8];
      chk("t2_p1_lane4", p1[159:128], 32'h40600000);
      chk("t2_p2_lane0", p2[31:0], 32'h3F800000);
      chk("t2_p2_lane1", p2[63:32], 32'h40000000);
      chk("t2_p2_lane3", p2[127:96], 32'h40600000);
      chk("t2_p2_lane4", p2[159:128], 32'h40600000);
      @(posedge clk); #1;

      // T4: back-to-back accept in the valid_out cycle; a valid_in while busy is dropped.
      run_vec(4, tbl[0].din, 30, lat, ns, mo, s0);
      chk("t4_first_lat", lat, 5);
      chk("t4_first_max", mo, 32'h40600000);
      din4 = tbl[1].din[127:0];
      vin4 = 1'b1;
      @(posedge clk); #1;
      chk("t4_busy_after_accept", {31'd0, busy4}, 32'd1);
      din4 = {4{32'h7F000000}};
      @(posedge clk); #1;
      vin4 = 1'b0;
      lat = -1;
      for (int k = 3; k <= 30 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (vout4) lat = k;
      end
      chk("t4_second_lat", lat, 5);
      chk("t4_second_max", mo4, 32'hBF000000);
      n_extra = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (vout4) n_extra++;
      end
      chk("t4_dropped_no_result", n_extra, 0);

      // T5: layer never answers.
      mute4 = 1'b1;
      din4 = tbl[0].din[127:0];
      vin4 = 1'b1;
      lat_err = -1;
      saw = 0;
      for (int k = 1; k <= 40 && lat_err < 0; k++) begin
         @(posedge clk); #1;
         vin4 = 1'b0;
         if (vout4) saw++;
         if (err4) lat_err = k;
      end
      chk("t5_err_latency", lat_err, 18);
      chk("t5_ready_at_err", {31'd0, rdy4}, 32'd1);
      chk("t5_no_valid_out", saw, 0);
      chk("t5_max_unchanged", mo4, 32'hBF000000);
      @(posedge clk); #1;
      chk("t5_err_one_cycle", {31'd0, err4}, 32'd0);

      // T6: reset during WAIT, then a stray layer result.
      din4 = tbl[0].din[127:0];
      vin4 = 1'b1;
      @(posedge clk); #1;
      vin4 = 1'b0;
      @(posedge clk); #1;
      chk("t6_busy_in_wait", {31'd0, busy4}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t6_ready_after_rst", {31'd0, rdy4}, 32'd1);
      chk("t6_busy_after_rst", {31'd0, busy4}, 32'd0);
      chk("t6_max_cleared", mo4, 32'd0);
      inj_data4 = {32'h40600000, 32'h40600000};
      inj4 = 1'b1;
      @(posedge clk); #1;
      inj4 = 1'b0;
      saw = (vout4) ? 1 : 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (vout4) saw++;
      end
      chk("t6_no_valid_out", saw, 0);
      chk("t6_max_still_zero", mo4, 32'd0);
      chk("t6_ready_idle", {31'd0, rdy4}, 32'd1);
      mute4 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
